// File: rtl/seq_defs.sv
// Shared definitions for the serial pattern generator and the sequence detectors.
// Holds the FSM state encoding and the default sizing parameters.
package seq_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_REP_W = 4;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control and serial-output bundle of the pattern generator.
// The master side requests transmissions; the generator is the slave.
interface seq_pattern_gen_if
    import seq_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, pattern, len, reps, abort,
        input  out, valid, busy, done, err
    );

    modport slave (
        input  start, pattern, len, reps, abort,
        output out, valid, busy, done, err
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, one bit per
// clock, for a programmable number of repetitions (reps = 0 runs until abort).
module seq_pattern_gen
    import seq_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_pattern_gen_if.slave bus
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] pat_q,   pat_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [REP_W-1:0] rep_q,   rep_d;
    logic [LEN_W-1:0] idx_q,   idx_d;
    logic             err_q,   err_d;

    logic             len_ok;
    logic [WIDTH-1:0] shifted;

    assign len_ok = (bus.len != '0) && (bus.len <= MAX_LEN);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort beats start, so a simultaneous pair neither loads nor flags err
                if (bus.start && !bus.abort) begin
                    if (len_ok) begin
                        pat_d   = bus.pattern;
                        len_d   = bus.len;
                        rep_d   = bus.reps;
                        idx_d   = bus.len - LEN_ONE;
                        state_d = ST_SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q == '0) begin
                    if (rep_q == REP_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = len_q - LEN_ONE;
                        if (rep_q != '0) begin
                            rep_d = rep_q - REP_ONE;
                        end
                    end
                end else begin
                    idx_d = idx_q - LEN_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode directly from flops so reset clears them without waiting for a clock.
    assign shifted   = pat_q >> idx_q;
    assign bus.out   = (state_q == ST_SHIFT) && shifted[0];
    assign bus.valid = (state_q == ST_SHIFT);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.err   = err_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed testbench for seq_pattern_gen; observed vector is {out, valid, busy, done, err}.
module tb_seq_pattern_gen;
    import seq_defs::*;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int REP_W = 4;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    seq_pattern_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

    seq_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [4:0] obs;
    assign obs = {bus.out, bus.valid, bus.busy, bus.done, bus.err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        bus.reps    = '0;
        #12;
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold: got %b, expected %b", obs, 5'b00000);
        end
        rst_n = 1'b1;
        step();
        step();
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got %b, expected %b", obs, 5'b00000);
        end
    endtask

    task automatic test_single();
        logic [4:0] exp [5] = '{5'b11100, 5'b01100, 5'b11100, 5'b00110, 5'b00000};
        bus.pattern = 8'b0000_0101;
        bus.len     = 4'd3;
        bus.reps    = 4'd1;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (obs !== exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL single[%0d]: got %b, expected %b", i, obs, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_reps2();
        logic [4:0] exp [8] = '{5'b11100, 5'b01100, 5'b11100, 5'b11100,
                                5'b01100, 5'b11100, 5'b00110, 5'b00000};
        bus.pattern = 8'b0000_0101;
        bus.len     = 4'd3;
        bus.reps    = 4'd2;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (obs !== exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL reps2[%0d]: got %b, expected %b", i, obs, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_len_bounds();
        logic [4:0] exp_a [10] = '{5'b11100, 5'b01100, 5'b11100, 5'b01100, 5'b01100,
                                   5'b11100, 5'b01100, 5'b11100, 5'b00110, 5'b00000};
        logic [4:0] exp_b [5]  = '{5'b11100, 5'b11100, 5'b11100, 5'b00110, 5'b00000};
        bus.pattern = 8'hA5;
        bus.len     = 4'd8;
        bus.reps    = 4'd1;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (obs !== exp_a[i]) begin
                tests_failed++;
                $display("[TB] FAIL len_max[%0d]: got %b, expected %b", i, obs, exp_a[i]);
            end
            step();
        end
        bus.pattern = 8'b0000_0001;
        bus.len     = 4'd1;
        bus.reps    = 4'd3;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (obs !== exp_b[i]) begin
                tests_failed++;
                $display("[TB] FAIL len_one[%0d]: got %b, expected %b", i, obs, exp_b[i]);
            end
            step();
        end
    endtask

    task automatic test_err();
        logic [LEN_W-1:0] bad_len [2] = '{4'd0, 4'd9};
        for (int k = 0; k < 2; k++) begin
            bus.pattern = 8'hFF;
            bus.len     = bad_len[k];
            bus.reps    = 4'd1;
            bus.start   = 1'b1;
            step();
            bus.start   = 1'b0;
            tests_run++;
            if (obs !== 5'b00001) begin
                tests_failed++;
                $display("[TB] FAIL err_pulse len=%0d: got %b, expected %b", bad_len[k], obs, 5'b00001);
            end
            step();
            tests_run++;
            if (obs !== 5'b00000) begin
                tests_failed++;
                $display("[TB] FAIL err_clear len=%0d: got %b, expected %b", bad_len[k], obs, 5'b00000);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [4:0] exp [8] = '{5'b11100, 5'b01100, 5'b11100, 5'b11100,
                                5'b01100, 5'b11100, 5'b00110, 5'b00000};
        bus.pattern = 8'b0000_0101;
        bus.len     = 4'd3;
        bus.reps    = 4'd2;
        bus.start   = 1'b1;
        step();
        bus.pattern = 8'hFF;
        bus.len     = 4'd8;
        bus.reps    = 4'd5;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (obs !== exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL busy_start[%0d]: got %b, expected %b", i, obs, exp[i]);
            end
            if (i == 7) bus.start = 1'b0;
            else step();
        end
        step();
    endtask

    task automatic test_continuous_abort();
        logic [4:0] exp;
        bus.pattern = 8'b0000_0010;
        bus.len     = 4'd2;
        bus.reps    = 4'd0;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            exp = {((i % 2) == 0) ? 1'b1 : 1'b0, 4'b1100};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL cont[%0d]: got %b, expected %b", i, obs, exp);
            end
            if (i < 39) step();
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL abort_stop: got %b, expected %b", obs, 5'b00000);
        end
        step();
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL abort_no_done: got %b, expected %b", obs, 5'b00000);
        end
    endtask

    task automatic test_abort_idle();
        bus.pattern = 8'b0000_0101;
        bus.len     = 4'd3;
        bus.reps    = 4'd1;
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL abort_beats_start: got %b, expected %b", obs, 5'b00000);
        end
        step();
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle_stays: got %b, expected %b", obs, 5'b00000);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp [5] = '{5'b11100, 5'b11100, 5'b01100, 5'b00110, 5'b00000};
        bus.pattern = 8'b0000_0101;
        bus.len     = 4'd3;
        bus.reps    = 4'd3;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        tests_run++;
        if (obs !== 5'b11100) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_first: got %b, expected %b", obs, 5'b11100);
        end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_async: got %b, expected %b", obs, 5'b00000);
        end
        step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_release: got %b, expected %b", obs, 5'b00000);
        end
        bus.pattern = 8'b0000_0110;
        bus.len     = 4'd3;
        bus.reps    = 4'd1;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (obs !== exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL rstmid_restart[%0d]: got %b, expected %b", i, obs, exp[i]);
            end
            step();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_reps2();
        test_len_bounds();
        test_err();
        test_start_while_busy();
        test_continuous_abort();
        test_abort_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
